// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM state type
// and the index-width helper.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_WR,
    ST_RMW_RD,
    ST_RMW_WR,
    ST_DONE
  } lsu_state_t;

  // Number of word-index bits for a memory of 'depth' 32-bit words.
  function automatic int idx_width(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request and memory-side bundle of the load/store unit.
// err_o exists only when LSU_MISALIGN_TRAP_EN is defined.
interface load_store_unit_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        MemRead_i;
  logic        MemWrite_i;
  logic [1:0]  size_i;
  logic        unsigned_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic [31:0] rdata_o;
  logic        done_o;
`ifdef LSU_MISALIGN_TRAP_EN
  logic        err_o;
`endif
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_read_o;
  logic        mem_write_o;
  logic [31:0] mem_rdata_i;

  modport slave (
    input  req_valid_i, MemRead_i, MemWrite_i, size_i, unsigned_i, addr_i, wdata_i, mem_rdata_i,
    output req_ready_o, rdata_o, done_o, mem_addr_o, mem_wdata_o, mem_read_o, mem_write_o
`ifdef LSU_MISALIGN_TRAP_EN
    , output err_o
`endif
  );

  modport master (
    output req_valid_i, MemRead_i, MemWrite_i, size_i, unsigned_i, addr_i, wdata_i, mem_rdata_i,
    input  req_ready_o, rdata_o, done_o, mem_addr_o, mem_wdata_o, mem_read_o, mem_write_o
`ifdef LSU_MISALIGN_TRAP_EN
    , input err_o
`endif
  );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: load extraction with sign/zero extension and
// subword merge for read-modify-write stores. Little-endian lanes.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_lane,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load,
  output logic [31:0] o_merge
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Select the addressed lane, then extend for loads or splice for stores.
  always_comb begin
    w_byte = 8'h00;
    case (i_lane)
      2'd0: w_byte = i_word[7:0];
      2'd1: w_byte = i_word[15:8];
      2'd2: w_byte = i_word[23:16];
      2'd3: w_byte = i_word[31:24];
    endcase
    w_half  = i_lane[1] ? i_word[31:16] : i_word[15:0];
    o_load  = i_word;
    o_merge = i_wdata;
    case (i_size)
      SZ_BYTE: begin
        o_load  = {{24{w_byte[7] & ~i_unsigned}}, w_byte};
        o_merge = i_word;
        case (i_lane)
          2'd0: o_merge[7:0]   = i_wdata[7:0];
          2'd1: o_merge[15:8]  = i_wdata[7:0];
          2'd2: o_merge[23:16] = i_wdata[7:0];
          2'd3: o_merge[31:24] = i_wdata[7:0];
        endcase
      end
      SZ_HALF: begin
        o_load  = {{16{w_half[15] & ~i_unsigned}}, w_half};
        o_merge = i_word;
        if (i_lane[1]) o_merge[31:16] = i_wdata[15:0];
        else           o_merge[15:0]  = i_wdata[15:0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one MEM-stage request at a time, sequences the
// word-indexed memory (subword stores as read-modify-write) and pulses
// done_o on completion. Define LSU_MISALIGN_TRAP_EN to trap misaligned
// half/word accesses with err_o instead of silently ignoring low bits.
//
// state     | meaning
// ----------+---------------------------------------------
// IDLE      | ready for a request
// RD        | load read, waiting MEM_LAT cycles
// WR        | full-word store write strobe
// RMW_RD    | subword store: reading the old word
// RMW_WR    | subword store: writing the merged word
// DONE      | done_o pulse, back to IDLE next cycle
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_LAT = 1,
  parameter int DEPTH   = 256
) (
  input logic              clk_i,
  input logic              rst_n_i,
  load_store_unit_if.slave bus
);

  localparam int         IDX_W  = idx_width(DEPTH);
  localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

  lsu_state_t  r_state;
  logic [3:0]  r_cnt;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [1:0]  r_size;
  logic        r_unsigned;
  logic [31:0] r_rdata;
  logic [31:0] r_word;
  logic        r_done;
  logic        r_err;

  logic [31:0] w_align_word;
  logic [31:0] w_load;
  logic [31:0] w_merge;
  logic        w_misalign;
  logic        w_unused_addr;

`ifdef LSU_MISALIGN_TRAP_EN
  assign w_misalign = ((bus.size_i == SZ_HALF) && bus.addr_i[0]) ||
                      (bus.size_i[1] && (bus.addr_i[1:0] != 2'b00));
  assign bus.err_o  = r_err;
`else
  logic w_unused_err;
  assign w_misalign   = 1'b0;
  assign w_unused_err = r_err;
`endif

  assign w_unused_addr = ^r_addr[31:IDX_W+2];

  // During RMW_WR the merge works on the sampled old word; otherwise the
  // live memory data feeds load extraction.
  assign w_align_word = (r_state == ST_RMW_WR) ? r_word : bus.mem_rdata_i;

  lsu_align u_align (
    .i_word     (w_align_word),
    .i_lane     (r_addr[1:0]),
    .i_size     (r_size),
    .i_unsigned (r_unsigned),
    .i_wdata    (r_wdata),
    .o_load     (w_load),
    .o_merge    (w_merge)
  );

  // Request capture, latency down-counter and state sequencing.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state    <= ST_IDLE;
      r_cnt      <= 4'd0;
      r_addr     <= 32'd0;
      r_wdata    <= 32'd0;
      r_size     <= 2'd0;
      r_unsigned <= 1'b0;
      r_rdata    <= 32'd0;
      r_word     <= 32'd0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (bus.req_valid_i) begin
            r_addr     <= bus.addr_i;
            r_wdata    <= bus.wdata_i;
            r_size     <= bus.size_i;
            r_unsigned <= bus.unsigned_i;
            if (w_misalign && (bus.MemRead_i || bus.MemWrite_i)) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
              r_err   <= 1'b1;
            end else if (bus.MemWrite_i) begin
              if (bus.size_i[1]) begin
                r_state <= ST_WR;
              end else begin
                r_state <= ST_RMW_RD;
                r_cnt   <= LAT_M1;
              end
            end else if (bus.MemRead_i) begin
              r_state <= ST_RD;
              r_cnt   <= LAT_M1;
            end else begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        ST_RD: begin
          if (r_cnt == 4'd0) begin
            r_rdata <= w_load;
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        ST_RMW_RD: begin
          if (r_cnt == 4'd0) begin
            r_word  <= bus.mem_rdata_i;
            r_state <= ST_RMW_WR;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        ST_WR, ST_RMW_WR: begin
          r_state <= ST_DONE;
          r_done  <= 1'b1;
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.req_ready_o = (r_state == ST_IDLE);
  assign bus.mem_read_o  = (r_state == ST_RD) || (r_state == ST_RMW_RD);
  assign bus.mem_write_o = (r_state == ST_WR) || (r_state == ST_RMW_WR);
  assign bus.mem_addr_o  = (r_state == ST_IDLE) ? 32'd0
                         : {{(32-IDX_W){1'b0}}, r_addr[IDX_W+1:2]};
  assign bus.mem_wdata_o = (r_state == ST_WR)     ? r_wdata
                         : (r_state == ST_RMW_WR) ? w_merge
                         : 32'd0;
  assign bus.done_o      = r_done;
  assign bus.rdata_o     = r_rdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with MEM_LAT = 3 against a
// combinational-read word memory model.
module tb_load_store_unit;
  import lsu_pkg::*;

  localparam int L = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  load_store_unit_if bus ();

  load_store_unit #(.MEM_LAT(L), .DEPTH(256)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  logic [31:0] mem [256];
  int          wr_total = 0;

  assign bus.mem_rdata_i = mem[bus.mem_addr_o[7:0]];

  // Memory write port and global write counter.
  always @(posedge clk) begin
    if (bus.mem_write_o) begin
      mem[bus.mem_addr_o[7:0]] <= bus.mem_wdata_o;
      wr_total <= wr_total + 1;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  int          g_n, g_rd, g_wr;
  logic        g_err, g_order_ok;
  logic [31:0] g_raddr, g_waddr, g_wdata;

  // Drive one request, release the inputs after acceptance and record the
  // strobe/done activity until done_o (bounded to 40 cycles, g_n = -1 if none).
  task automatic issue(input logic rd, input logic wr, input logic [1:0] sz,
                       input logic uns, input logic [31:0] a, input logic [31:0] wd);
    @(negedge clk);
    bus.req_valid_i = 1'b1; bus.MemRead_i = rd; bus.MemWrite_i = wr;
    bus.size_i = sz; bus.unsigned_i = uns; bus.addr_i = a; bus.wdata_i = wd;
    @(posedge clk);
    #1;
    bus.req_valid_i = 1'b0; bus.MemRead_i = 1'b0; bus.MemWrite_i = 1'b0;
    bus.addr_i = 32'hFFFF_FFFF; bus.wdata_i = 32'h5555_5555;
    bus.size_i = 2'b00; bus.unsigned_i = ~uns;
    g_n = -1; g_rd = 0; g_wr = 0; g_err = 1'b0; g_order_ok = 1'b1;
    g_raddr = '1; g_waddr = '1; g_wdata = '0;
    for (int c = 1; c <= 40 && g_n < 0; c++) begin
      @(negedge clk);
      if (bus.mem_read_o) begin
        g_rd++; g_raddr = bus.mem_addr_o;
        if (g_wr != 0) g_order_ok = 1'b0;
      end
      if (bus.mem_write_o) begin
        g_wr++; g_waddr = bus.mem_addr_o; g_wdata = bus.mem_wdata_o;
      end
      if (bus.done_o) begin
        g_n = c;
`ifdef LSU_MISALIGN_TRAP_EN
        g_err = bus.err_o;
`endif
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp++; if (bus.req_ready_o !== 1'b1) begin n_bad++; $display("FAIL reset_ready got=%b exp=1", bus.req_ready_o); end
    n_cmp++; if (bus.done_o !== 1'b0) begin n_bad++; $display("FAIL reset_done got=%b exp=0", bus.done_o); end
    n_cmp++; if (bus.rdata_o !== 32'd0) begin n_bad++; $display("FAIL reset_rdata got=%h exp=0", bus.rdata_o); end
    n_cmp++; if ({bus.mem_read_o, bus.mem_write_o} !== 2'b00) begin n_bad++; $display("FAIL reset_strobes got=%b%b exp=00", bus.mem_read_o, bus.mem_write_o); end
    n_cmp++; if (bus.mem_addr_o !== 32'd0 || bus.mem_wdata_o !== 32'd0) begin n_bad++; $display("FAIL reset_membus addr=%h wdata=%h exp=0/0", bus.mem_addr_o, bus.mem_wdata_o); end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.req_ready_o !== 1'b1) begin n_bad++; $display("FAIL post_reset_ready got=%b exp=1", bus.req_ready_o); end
  endtask

  task automatic test_word_store_load();
    issue(1'b0, 1'b1, SZ_WORD, 1'b0, 32'h10, 32'hDEAD_BEEF);
    n_cmp++; if (g_n !== 2) begin n_bad++; $display("FAIL wst_latency got=%0d exp=2", g_n); end
    n_cmp++; if (g_wr !== 1 || g_rd !== 0) begin n_bad++; $display("FAIL wst_strobes wr=%0d rd=%0d exp=1/0", g_wr, g_rd); end
    n_cmp++; if (g_waddr !== 32'd4 || g_wdata !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL wst_bus addr=%h data=%h exp=4/deadbeef", g_waddr, g_wdata); end
    n_cmp++; if (bus.rdata_o !== 32'd0) begin n_bad++; $display("FAIL wst_rdata_hold got=%h exp=0", bus.rdata_o); end
    issue(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0);
    n_cmp++; if (g_n !== L + 1) begin n_bad++; $display("FAIL wld_latency got=%0d exp=%0d", g_n, L + 1); end
    n_cmp++; if (g_rd !== L || g_wr !== 0 || g_raddr !== 32'd4) begin n_bad++; $display("FAIL wld_strobes rd=%0d wr=%0d addr=%h exp=%0d/0/4", g_rd, g_wr, g_raddr, L); end
    n_cmp++; if (bus.rdata_o !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL wld_rdata got=%h exp=deadbeef", bus.rdata_o); end
  endtask

  task automatic test_load_extension();
    logic [31:0] t_addr [7] = '{32'h09, 32'h0B, 32'h0B, 32'h08, 32'h0A, 32'h08, 32'h0A};
    logic [1:0]  t_size [7] = '{SZ_BYTE, SZ_BYTE, SZ_BYTE, SZ_BYTE, SZ_HALF, SZ_HALF, SZ_HALF};
    logic        t_uns  [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [31:0] t_exp  [7] = '{32'h0000_007F, 32'hFFFF_FF80, 32'h0000_0080, 32'h0000_0001,
                                32'hFFFF_80FF, 32'h0000_7F01, 32'h0000_80FF};
    issue(1'b0, 1'b1, SZ_WORD, 1'b0, 32'h08, 32'h80FF_7F01);
    for (int i = 0; i < 7; i++) begin
      issue(1'b1, 1'b0, t_size[i], t_uns[i], t_addr[i], 32'h0);
      n_cmp++;
      if (bus.rdata_o !== t_exp[i] || g_n !== L + 1) begin
        n_bad++; $display("FAIL ext_load[%0d] got=%h n=%0d exp=%h n=%0d", i, bus.rdata_o, g_n, t_exp[i], L + 1);
      end
    end
  endtask

  task automatic test_subword_rmw();
    issue(1'b0, 1'b1, SZ_WORD, 1'b0, 32'h04, 32'h1122_3344);
    issue(1'b0, 1'b1, SZ_HALF, 1'b0, 32'h06, 32'h9999_ABCD);
    n_cmp++; if (g_n !== L + 2) begin n_bad++; $display("FAIL rmw_half_latency got=%0d exp=%0d", g_n, L + 2); end
    n_cmp++; if (g_rd !== L || g_wr !== 1 || g_order_ok !== 1'b1) begin n_bad++; $display("FAIL rmw_half_strobes rd=%0d wr=%0d order=%b exp=%0d/1/1", g_rd, g_wr, g_order_ok, L); end
    n_cmp++; if (g_waddr !== 32'd1 || g_wdata !== 32'hABCD_3344) begin n_bad++; $display("FAIL rmw_half_word addr=%h data=%h exp=1/abcd3344", g_waddr, g_wdata); end
    n_cmp++; if (bus.rdata_o !== 32'h0000_80FF) begin n_bad++; $display("FAIL rmw_rdata_hold got=%h exp=000080ff", bus.rdata_o); end
    issue(1'b0, 1'b1, SZ_BYTE, 1'b1, 32'h05, 32'h0000_005A);
    n_cmp++; if (g_wdata !== 32'hABCD_5A44 || g_n !== L + 2) begin n_bad++; $display("FAIL rmw_byte data=%h n=%0d exp=abcd5a44 n=%0d", g_wdata, g_n, L + 2); end
    issue(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h404, 32'h0);
    n_cmp++; if (g_raddr !== 32'd1 || bus.rdata_o !== 32'hABCD_5A44) begin n_bad++; $display("FAIL wrap_load addr=%h data=%h exp=1/abcd5a44", g_raddr, bus.rdata_o); end
  endtask

  task automatic test_priority_noop();
    issue(1'b1, 1'b1, SZ_WORD, 1'b0, 32'h20, 32'h1234_5678);
    n_cmp++; if (g_wr !== 1 || g_rd !== 0 || g_n !== 2 || g_wdata !== 32'h1234_5678) begin n_bad++; $display("FAIL both_is_store wr=%0d rd=%0d n=%0d data=%h exp=1/0/2/12345678", g_wr, g_rd, g_n, g_wdata); end
    issue(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h20, 32'h0);
    n_cmp++; if (bus.rdata_o !== 32'h1234_5678) begin n_bad++; $display("FAIL both_readback got=%h exp=12345678", bus.rdata_o); end
    issue(1'b0, 1'b0, SZ_WORD, 1'b0, 32'h20, 32'hFFFF_FFFF);
    n_cmp++; if (g_n !== 1 || g_rd !== 0 || g_wr !== 0) begin n_bad++; $display("FAIL noop n=%0d rd=%0d wr=%0d exp=1/0/0", g_n, g_rd, g_wr); end
    n_cmp++; if (bus.rdata_o !== 32'h1234_5678) begin n_bad++; $display("FAIL noop_rdata got=%h exp=12345678", bus.rdata_o); end
  endtask

  task automatic test_back_to_back();
    int acc = 0, dn = 0, viol = 0;
    logic busy = 1'b0;
    @(negedge clk);
    bus.req_valid_i = 1'b1; bus.MemRead_i = 1'b1; bus.MemWrite_i = 1'b0;
    bus.size_i = SZ_WORD; bus.unsigned_i = 1'b0; bus.addr_i = 32'h20;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (busy && bus.req_ready_o) viol++;
      if (bus.done_o) begin
        if (!busy) viol++;
        busy = 1'b0; dn++;
      end
      if (bus.req_ready_o) begin busy = 1'b1; acc++; end
      if (c == 19) begin bus.req_valid_i = 1'b0; bus.MemRead_i = 1'b0; end
      @(negedge clk);
    end
    n_cmp++; if (acc !== 4) begin n_bad++; $display("FAIL b2b_accepts got=%0d exp=4", acc); end
    n_cmp++; if (dn !== 4) begin n_bad++; $display("FAIL b2b_dones got=%0d exp=4", dn); end
    n_cmp++; if (viol !== 0) begin n_bad++; $display("FAIL b2b_overlap got=%0d exp=0", viol); end
  endtask

  task automatic test_reset_mid_access();
    int wr_before;
    @(negedge clk);
    bus.req_valid_i = 1'b1; bus.MemRead_i = 1'b0; bus.MemWrite_i = 1'b1;
    bus.size_i = SZ_HALF; bus.unsigned_i = 1'b0; bus.addr_i = 32'h06; bus.wdata_i = 32'h0000_7777;
    @(posedge clk);
    #1 bus.req_valid_i = 1'b0; bus.MemWrite_i = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.mem_read_o !== 1'b1) begin n_bad++; $display("FAIL rst_mid_inflight rd=%b exp=1", bus.mem_read_o); end
    wr_before = wr_total;
    #1 rst_n = 1'b0;
    #1;
    n_cmp++; if ({bus.mem_read_o, bus.mem_write_o, bus.done_o} !== 3'b000) begin n_bad++; $display("FAIL rst_mid_strobes got=%b%b%b exp=000", bus.mem_read_o, bus.mem_write_o, bus.done_o); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      n_cmp++; if (bus.done_o !== 1'b0 || bus.req_ready_o !== 1'b1) begin n_bad++; $display("FAIL rst_mid_after done=%b ready=%b exp=0/1", bus.done_o, bus.req_ready_o); end
    end
    n_cmp++; if (wr_total !== wr_before) begin n_bad++; $display("FAIL rst_mid_nowrite got=%0d exp=%0d", wr_total, wr_before); end
    issue(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h04, 32'h0);
    n_cmp++; if (bus.rdata_o !== 32'hABCD_5A44) begin n_bad++; $display("FAIL rst_mid_memword got=%h exp=abcd5a44", bus.rdata_o); end
  endtask

  task automatic test_misalign();
    issue(1'b0, 1'b1, SZ_WORD, 1'b0, 32'h00, 32'hCAFE_F00D);
    issue(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h03, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
    n_cmp++; if (g_n !== 1 || g_err !== 1'b1) begin n_bad++; $display("FAIL misalign_trap n=%0d err=%b exp=1/1", g_n, g_err); end
    n_cmp++; if (g_rd !== 0 || g_wr !== 0) begin n_bad++; $display("FAIL misalign_strobes rd=%0d wr=%0d exp=0/0", g_rd, g_wr); end
    n_cmp++; if (bus.rdata_o !== 32'hABCD_5A44) begin n_bad++; $display("FAIL misalign_rdata got=%h exp=abcd5a44", bus.rdata_o); end
    issue(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h00, 32'h0);
    n_cmp++; if (g_err !== 1'b0 || bus.rdata_o !== 32'hCAFE_F00D) begin n_bad++; $display("FAIL aligned_noerr err=%b data=%h exp=0/cafef00d", g_err, bus.rdata_o); end
`else
    n_cmp++; if (g_n !== L + 1 || g_raddr !== 32'd0) begin n_bad++; $display("FAIL misalign_ignored n=%0d addr=%h exp=%0d/0", g_n, g_raddr, L + 1); end
    n_cmp++; if (bus.rdata_o !== 32'hCAFE_F00D) begin n_bad++; $display("FAIL misalign_rdata got=%h exp=cafef00d", bus.rdata_o); end
`endif
  endtask

  initial begin
    bus.req_valid_i = 1'b0; bus.MemRead_i = 1'b0; bus.MemWrite_i = 1'b0;
    bus.size_i = 2'b00; bus.unsigned_i = 1'b0; bus.addr_i = 32'd0; bus.wdata_i = 32'd0;
    test_reset();
    test_word_store_load();
    test_load_extension();
    test_subword_rmw();
    test_priority_noop();
    test_back_to_back();
    test_reset_mid_access();
    test_misalign();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

endmodule
